piezo_seq: RTL and testbench

- Parametrised successor to the single-tune piezo driver. Sequences one of three prioritised alert tunes (overspeed, battery-low, steering-enabled) onto a differential piezo pair.
- Note pitch, duration scaling and repeat interval are parameters. Adds immediate pre-emption by a higher-priority tune, per-tune repeat gating, and busy/tune-ID status outputs.
- Sits beside the balance controller and takes its alarm flags directly.

---
 rtl/piezo_seq.sv | 168 ++++++++++++++++
 tb/tb_piezo_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/piezo_seq.sv
// Prioritised three-tune piezo sequencer driving a differential piezo pair.
// Supports pre-emption by a higher-priority tune and per-tune repeat gating.
module piezo_seq #(
    parameter int FAST_SIM    = 0,
    parameter int SIM_SHIFT   = 9,
    parameter int PER_W       = 15,
    parameter int DUR_W       = 25,
    parameter int RPT_W       = 28,
    parameter int REPEAT_CLKS = 150000000,
    parameter int REPEAT_SIM  = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       too_fast,
    input  logic       batt_low,
    input  logic       en_steer,
    output logic       piezo,
    output logic       piezo_n,
    output logic       busy,
    output logic [1:0] tune_id
);

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    localparam logic [1:0] TUNE_NONE  = 2'd0;
    localparam logic [1:0] TUNE_FAST  = 2'd1;
    localparam logic [1:0] TUNE_BATT  = 2'd2;
    localparam logic [1:0] TUNE_STEER = 2'd3;

    localparam int SHIFT    = (FAST_SIM != 0) ? SIM_SHIFT : 0;
    // Loaded with interval-1 so the same tune can restart exactly REPEAT clocks after its start.
    localparam int RPT_LOAD = ((FAST_SIM != 0) ? REPEAT_SIM : REPEAT_CLKS) - 1;

    function automatic logic [PER_W-1:0] note_per(input logic [2:0] idx);
        int p;
        case (idx)
            3'd0:       p = 31888;
            3'd1:       p = 23890;
            3'd2, 3'd4: p = 18961;
            default:    p = 15944;
        endcase
        return PER_W'(p >> SHIFT);
    endfunction

    function automatic logic [DUR_W-1:0] note_dur(input logic [2:0] idx);
        int d;
        case (idx)
            3'd0, 3'd1, 3'd2: d = 1 << 23;
            3'd3:             d = (1 << 23) + (1 << 22);
            3'd4:             d = 1 << 22;
            default:          d = 1 << 24;
        endcase
        return DUR_W'(d >> SHIFT);
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       tune_q, tune_d;
    logic [2:0]       note_q, note_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;

    logic [1:0]       req_id;
    logic             start;
    logic             load;
    logic [2:0]       load_idx;
    logic             last_note;
    logic [PER_W-1:0] half;
    logic             wave_hi;

    // Only overspeed bypasses the repeat gate; the other two share one counter.
    always_comb begin
        req_id = TUNE_NONE;
        if (too_fast) begin
            req_id = TUNE_FAST;
        end else if (rpt_q == '0) begin
            if (batt_low)      req_id = TUNE_BATT;
            else if (en_steer) req_id = TUNE_STEER;
        end
    end

    always_comb begin
        last_note = 1'b0;
        case (tune_q)
            TUNE_FAST:  last_note = (note_q == 3'd2);
            TUNE_BATT:  last_note = (note_q == 3'd0);
            TUNE_STEER: last_note = (note_q == 3'd5);
            default:    last_note = 1'b1;
        endcase
    end

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d  = state_q;
        tune_d   = tune_q;
        note_d   = note_q;
        per_d    = per_q;
        dur_d    = dur_q;
        rpt_d    = (rpt_q != '0) ? rpt_q - RPT_W'(1) : '0;
        start    = 1'b0;
        load     = 1'b0;
        load_idx = note_q;

        unique case (state_q)
            IDLE: start = (req_id != TUNE_NONE);
            PLAY: begin
                if (req_id != TUNE_NONE && req_id < tune_q) begin
                    start = 1'b1;
                end else if (dur_q == '0) begin
                    if (!last_note) begin
                        load     = 1'b1;
                        load_idx = (tune_q == TUNE_BATT) ? note_q - 3'd1 : note_q + 3'd1;
                    end else if (tune_q == TUNE_FAST && too_fast) begin
                        load     = 1'b1;
                        load_idx = 3'd0;
                    end else begin
                        state_d = IDLE;
                        tune_d  = TUNE_NONE;
                    end
                end else begin
                    dur_d = dur_q - DUR_W'(1);
                    per_d = (per_q == '0) ? note_per(note_q) - PER_W'(1) : per_q - PER_W'(1);
                end
            end
        endcase

        if (start) begin
            state_d  = PLAY;
            tune_d   = req_id;
            load     = 1'b1;
            load_idx = (req_id == TUNE_BATT) ? 3'd5 : 3'd0;
            if (req_id != TUNE_FAST) rpt_d = RPT_W'(RPT_LOAD);
        end

        if (load) begin
            note_d = load_idx;
            per_d  = note_per(load_idx) - PER_W'(1);
            dur_d  = note_dur(load_idx) - DUR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tune_q  <= TUNE_NONE;
            note_q  <= '0;
            per_q   <= '0;
            dur_q   <= '0;
            rpt_q   <= '0;
        end else begin
            state_q <= state_d;
            tune_q  <= tune_d;
            note_q  <= note_d;
            per_q   <= per_d;
            dur_q   <= dur_d;
            rpt_q   <= rpt_d;
        end
    end

    assign half    = note_per(note_q) >> 1;
    assign wave_hi = (per_q >= half);
    assign busy    = (state_q == PLAY);
    assign tune_id = tune_q;
    assign piezo   = busy & wave_hi;
    assign piezo_n = busy & ~wave_hi;

endmodule

// File: tb/tb_piezo_seq.sv
// Directed bench for piezo_seq with FAST_SIM=1, SIM_SHIFT=12 (periods 7/5/4/3/4/3,
// durations 2048/2048/2048/3072/1024/4096) and a 16000-clock repeat interval.
module tb_piezo_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       too_fast, batt_low, en_steer;
    logic       piezo, piezo_n, busy;
    logic [1:0] tune_id;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pair_bad = 0;

    piezo_seq #(
        .FAST_SIM  (1),
        .SIM_SHIFT (12),
        .REPEAT_SIM(16000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .too_fast(too_fast),
        .batt_low(batt_low),
        .en_steer(en_steer),
        .piezo   (piezo),
        .piezo_n (piezo_n),
        .busy    (busy),
        .tune_id (tune_id)
    );

    always #5 clk = ~clk;

    // Differential pair must be complementary while playing and fully off while idle.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (piezo_n !== ~piezo) pair_bad++;
        end else if (busy === 1'b0) begin
            if (piezo !== 1'b0 || piezo_n !== 1'b0) pair_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target) tick();
    endtask

    // Counts high then low samples of one waveform period starting at a high sample.
    task automatic measure(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (piezo === 1'b1 && hi < 100) begin hi++; tick(); end
        while (piezo === 1'b0 && lo < 100) begin lo++; tick(); end
    endtask

    task automatic check_note(input string tag, input int exp_hi, input int exp_lo);
        int hi, lo;
        check({tag, "_start_hi"}, piezo, 1);
        measure(hi, lo);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tune"}, tune_id, 0);
        check({tag, "_piezo"}, piezo, 0);
        check({tag, "_piezo_n"}, piezo_n, 0);
    endtask

    int s, s2, s3, s4, sf, sf2;

    initial begin
        rst_n = 1'b0; too_fast = 1'b0; batt_low = 1'b0; en_steer = 1'b0;
        tick(); tick(); tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        // en_steer single pulse: ascending notes 0..5
        en_steer = 1'b1;
        tick();
        en_steer = 1'b0;
        s = cyc;
        check("steer_tune", tune_id, 3);
        check("steer_busy", busy, 1);
        check("steer_pn", piezo_n, 0);
        check_note("steer_n0", 4, 3);
        goto(s + 2048);  check_note("steer_n1", 3, 2);
        goto(s + 4096);  check_note("steer_n2", 2, 2);
        goto(s + 6144);  check_note("steer_n3", 2, 1);
        goto(s + 9216);  check_note("steer_n4", 2, 2);
        goto(s + 10240); check_note("steer_n5", 2, 1);
        goto(s + 14335); check("steer_last_busy", busy, 1);
        tick();          check_idle("steer_end");

        // Second en_steer inside the repeat window is ignored
        goto(s + 15000);
        en_steer = 1'b1;
        tick();
        en_steer = 1'b0;
        check("steer_gated_busy", busy, 0);

        // batt_low held: starts when repeat window closes, descending notes 5..0
        batt_low = 1'b1;
        goto(s + 15999); check("batt_wait_busy", busy, 0);
        tick();
        s2 = cyc;
        check("batt_tune", tune_id, 2);
        check("batt_busy", busy, 1);
        check_note("batt_n5", 2, 1);
        goto(s2 + 4096);  check_note("batt_n4", 2, 2);
        goto(s2 + 5120);  check_note("batt_n3", 2, 1);
        goto(s2 + 8192);  check_note("batt_n2", 2, 2);
        goto(s2 + 10240); check_note("batt_n1", 3, 2);
        goto(s2 + 12288); check_note("batt_n0", 4, 3);
        goto(s2 + 14335); check("batt_last_busy", busy, 1);
        tick();           check_idle("batt_end");
        goto(s2 + 15999); check("batt_rpt_wait", busy, 0);
        tick();
        s3 = cyc;
        check("batt_restart_tune", tune_id, 2);

        // Request drop mid-tune does not abort; held lower-priority en_steer never pre-empts
        batt_low = 1'b0;
        en_steer = 1'b1;
        goto(s3 + 100);
        check("batt_drop_busy", busy, 1);
        check("batt_no_preempt", tune_id, 2);

        // too_fast pre-empts batt_low on the next clock and loops notes 0,1,2
        too_fast = 1'b1;
        tick();
        sf = cyc;
        check("fast_preempt_tune", tune_id, 1);
        check_note("fast_n0", 4, 3);
        goto(sf + 2048); check_note("fast_n1", 3, 2);
        goto(sf + 6144);
        check("fast_loop_tune", tune_id, 1);
        check_note("fast_loop_n0", 4, 3);
        goto(sf + 7000);
        too_fast = 1'b0;
        goto(sf + 12287); check("fast_last_tune", tune_id, 1);
        tick();           check_idle("fast_end");

        // en_steer held: accepted once the batt_low repeat window closes
        goto(s3 + 15999); check("steer2_wait", busy, 0);
        tick();
        s4 = cyc;
        check("steer2_tune", tune_id, 3);
        en_steer = 1'b0;

        // too_fast during en_steer note 2
        goto(s4 + 4100);
        too_fast = 1'b1;
        tick();
        sf2 = cyc;
        too_fast = 1'b0;
        check("fast2_tune", tune_id, 1);
        check_note("fast2_n0", 4, 3);

        // Reset mid-note silences outputs; requests are accepted right after
        goto(sf2 + 100);
        rst_n = 1'b0;
        tick();
        check_idle("midreset");
        rst_n = 1'b1;
        batt_low = 1'b1;
        en_steer = 1'b1;
        tick();
        check("simul_tune", tune_id, 2);
        check("simul_busy", busy, 1);
        batt_low = 1'b0;
        en_steer = 1'b0;
        tick(); tick();

        check("pair_violations", pair_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
